adc_frame_streamer: RTL

Packetizes 8-bit ADC samples into fixed-length frames and feeds them, one byte at a time, to the UART transmitter through its `dataOut`/`readyToTransmit` inputs. It sits directly upstream of the UART: it buffers samples arriving from the ADC capture logic and paces byte launches so that every byte finishes on the line before the next one starts. The UART has no busy flag, so pacing is owned entirely by this block.

---
 rtl/adc_stream_pkg.sv | 27 ++
 rtl/adc_frame_streamer_sample_fifo.sv | 48 ++++
 rtl/adc_frame_streamer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the ADC frame streamer.
// Define ADC_FRAME_CSUM_EN to add the trailing checksum byte to every frame.
package adc_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_DATA,
`ifdef ADC_FRAME_CSUM_EN
    ST_CSUM,
`endif
    ST_DRAIN
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bytes on the wire per frame: SYNC + SEQ + samples [+ CSUM].
  function automatic int frame_bytes(input int frame_samples);
`ifdef ADC_FRAME_CSUM_EN
    return frame_samples + 3;
`else
    return frame_samples + 2;
`endif
  endfunction

endpackage

// File: rtl/adc_frame_streamer_sample_fifo.sv
// sample_fifo: synchronous FIFO with a show-ahead head word; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  // The extra pointer bit separates full from empty when the low bits match.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (AW + 1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; only the pointers are,
  // which keeps it mappable to RAM and makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc_frame_streamer.sv
// adc_frame_streamer: buffers ADC samples and emits SYNC/SEQ/data frames to a UART,
// one byte per BYTE_PERIOD clocks. Define ADC_FRAME_CSUM_EN to append a CSUM byte.
module adc_frame_streamer
  import adc_stream_pkg::*;
#(
  parameter int         DELAY_FRAMES  = 234,
  parameter int         BYTE_PERIOD   = 2400,
  parameter int         FIFO_DEPTH    = 16,
  parameter int         FRAME_SAMPLES = 8,
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   sample_in,
  input  logic                         sample_valid,
  input  logic                         enable,
  output logic [7:0]                   dataOut,
  output logic                         readyToTransmit,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  // Never launch faster than one full 10-bit UART character plus margin.
  localparam int MIN_PERIOD = 10 * DELAY_FRAMES + 2;
  localparam int PERIOD     = (BYTE_PERIOD < MIN_PERIOD) ? MIN_PERIOD : BYTE_PERIOD;
  localparam int PW         = $clog2(PERIOD);
  localparam int CW         = $clog2(FRAME_SAMPLES + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pacer_q, pacer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    data_q, data_d;
  logic          rtt_q, rtt_d;
  logic          ovf_q, ovf_d;
  logic          frame_rdy_q;
  logic          push_req, pop_req, pop, launch, expired;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [LW-1:0] level;
`ifdef ADC_FRAME_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  assign push_req = sample_valid && enable;
  assign pop      = pop_req && !fifo_empty;
  assign expired  = (pacer_q == '0);

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i (sample_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pacer_d = expired ? pacer_q : pacer_q - 1'b1;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    data_d  = data_q;
    rtt_d   = 1'b0;
    pop_req = 1'b0;
    launch  = 1'b0;
`ifdef ADC_FRAME_CSUM_EN
    csum_d  = csum_q;
`endif
    ovf_d   = ovf_q | (push_req & fifo_full & ~pop);

    unique case (state_q)
      ST_IDLE: begin
        if (enable && frame_rdy_q) begin
          state_d = ST_SYNC;
          data_d  = SYNC_BYTE;
          launch  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (expired) begin
          state_d = ST_SEQ;
          data_d  = seq_q;
          seq_d   = seq_q + 8'd1;
          cnt_d   = '0;
          launch  = 1'b1;
`ifdef ADC_FRAME_CSUM_EN
          csum_d  = seq_q;
`endif
        end
      end
      ST_SEQ, ST_DATA: begin
        if (cnt_q != CW'(FRAME_SAMPLES)) begin
          if (expired) begin
            state_d = ST_DATA;
            data_d  = fifo_head;
            pop_req = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            launch  = 1'b1;
`ifdef ADC_FRAME_CSUM_EN
            csum_d  = csum_q + fifo_head;
`endif
          end
        end else begin
`ifdef ADC_FRAME_CSUM_EN
          if (expired) begin
            state_d = ST_CSUM;
            data_d  = csum_q;
            launch  = 1'b1;
          end
`else
          state_d = ST_DRAIN;
`endif
        end
      end
`ifdef ADC_FRAME_CSUM_EN
      ST_CSUM: state_d = ST_DRAIN;
`endif
      // The last byte is still on the line until the pacer runs out.
      ST_DRAIN: begin
        if (expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      rtt_d   = 1'b1;
      pacer_d = PW'(PERIOD - 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pacer_q     <= '0;
      cnt_q       <= '0;
      seq_q       <= 8'h00;
      data_q      <= 8'h00;
      rtt_q       <= 1'b0;
      ovf_q       <= 1'b0;
      frame_rdy_q <= 1'b0;
`ifdef ADC_FRAME_CSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      pacer_q     <= pacer_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      data_q      <= data_d;
      rtt_q       <= rtt_d;
      ovf_q       <= ovf_d;
      frame_rdy_q <= (level >= LW'(FRAME_SAMPLES));
`ifdef ADC_FRAME_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign dataOut         = data_q;
  assign readyToTransmit = rtt_q;
  assign overflow        = ovf_q;
  assign fifo_level      = level;

endmodule
